// File: rtl/tv_pkg.sv
// Shared types and helpers for the tv_player test-vector player.
// Holds the FSM state encoding, vector field layout and the saturating counter step.
package tv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } tv_state_e;

  // Vector word layout is {inputs, expected}: the expected value sits at bit 0
  // and the inputs start directly above it.
  localparam int unsigned EXP_LSB = 0;

  function automatic int unsigned in_lsb(input int unsigned out_w);
    return out_w;
  endfunction

  function automatic int unsigned in_msb(input int unsigned in_w, input int unsigned out_w);
    return in_w + out_w - 1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max;
    max = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v == max) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/tv_mem.sv
// Vector memory: synchronous write, combinational read, contents not reset.
module tv_mem #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned W     = 3
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/tv_player.sv
// Test-vector player/checker driving a small combinational DUT from a loaded vector memory.
// Define TV_PLAYER_STOP_ON_ERROR_EN to end a run at the first failing compare.
module tv_player
  import tv_pkg::*;
#(
  parameter int unsigned IN_W   = 2,
  parameter int unsigned OUT_W  = 1,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned SETTLE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ld_valid,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [IN_W+OUT_W-1:0]    ld_data,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   num_tests,
  output logic [IN_W-1:0]          dut_in,
  input  logic [OUT_W-1:0]         dut_out,
  output logic                     busy,
  output logic                     done,
  output logic                     mismatch,
  output logic [$clog2(DEPTH):0]   err_count,
  output logic [$clog2(DEPTH):0]   vec_idx
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned VW = IN_W + OUT_W;
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SET_LAST = SW'((SETTLE > 0) ? SETTLE - 1 : 0);

  tv_state_e         state_q, state_d;
  logic [CW-1:0]     n_q, n_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     err_q, err_d;
  logic [IN_W-1:0]   din_q, din_d;
  logic [OUT_W-1:0]  exp_q, exp_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic [VW-1:0]     rdata;
  logic              miss;

  assign busy = (state_q == ST_APPLY) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);

  tv_mem #(.DEPTH(DEPTH), .W(VW)) u_mem (
    .clk   (clk),
    .we    (ld_valid && !busy),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (idx_q[AW-1:0]),
    .rdata (rdata)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    idx_d    = idx_q;
    err_d    = err_q;
    din_d    = din_q;
    exp_d    = exp_q;
    cnt_d    = cnt_q;
    miss     = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          n_d     = (num_tests > CW'(DEPTH)) ? CW'(DEPTH) : num_tests;
          idx_d   = '0;
          err_d   = '0;
          state_d = (num_tests == '0) ? ST_DONE : ST_APPLY;
        end
      end
      ST_APPLY: begin
        din_d   = rdata[in_msb(IN_W, OUT_W):in_lsb(OUT_W)];
        exp_d   = rdata[EXP_LSB +: OUT_W];
        cnt_d   = '0;
        state_d = (SETTLE > 0) ? ST_SETTLE : ST_CHECK;
      end
      ST_SETTLE: begin
        if (cnt_q == SET_LAST) state_d = ST_CHECK;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_CHECK: begin
        miss  = (dut_out !== exp_q);
        if (miss) err_d = CW'(sat_inc(32'(err_q), CW));
`ifdef TV_PLAYER_STOP_ON_ERROR_EN
        if (miss) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = (idx_q + 1'b1 == n_q) ? ST_DONE : ST_APPLY;
        end
`else
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q + 1'b1 == n_q) ? ST_DONE : ST_APPLY;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      din_q   <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      din_q   <= din_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dut_in    = din_q;
  assign done      = (state_q == ST_DONE);
  assign mismatch  = miss;
  assign err_count = err_q;
  assign vec_idx   = idx_q;

endmodule

// File: tb/tb_tv_player.sv
// Scoreboard bench for tv_player driving a 2-input NAND; follows TV_PLAYER_STOP_ON_ERROR_EN if defined.
module tb_tv_player;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld_valid;
  logic [4:0] ld_addr;
  logic [2:0] ld_data;
  logic       start;
  logic [5:0] num_tests;
  logic [1:0] dut_in;
  logic       dut_out;
  logic       busy, done, mismatch;
  logic [5:0] err_count, vec_idx;

  typedef struct {
    logic [1:0] din;
    logic       mis;
  } sb_t;

  sb_t        sb[$];
  logic [2:0] tb_mem [32];
  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  assign dut_out = ~&dut_in;

  tv_player #(.IN_W(2), .OUT_W(1), .DEPTH(32), .SETTLE(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .start     (start),
    .num_tests (num_tests),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .busy      (busy),
    .done      (done),
    .mismatch  (mismatch),
    .err_count (err_count),
    .vec_idx   (vec_idx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load(input int unsigned addr, input logic [2:0] data);
    @(negedge clk);
    ld_valid = 1'b1;
    ld_addr  = 5'(addr);
    ld_data  = data;
    tb_mem[addr] = data;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_din"},  32'(dut_in),    32'd0);
    check({tag, "_busy"}, 32'(busy),      32'd0);
    check({tag, "_done"}, 32'(done),      32'd0);
    check({tag, "_mis"},  32'(mismatch),  32'd0);
    check({tag, "_err"},  32'(err_count), 32'd0);
    check({tag, "_idx"},  32'(vec_idx),   32'd0);
  endtask

  // disturb >= 0: during that vector's settle cycle, pulse a write to addr 0 and start.
  task automatic run(input int unsigned nt, input int disturb);
    int unsigned n, errs, last_idx, k;
    logic [1:0]  last_din;
    sb_t         e;
    n = (nt > 32) ? 32 : nt;
    errs = 0;
    last_idx = n;
    last_din = dut_in;
    sb.delete();
    for (int unsigned i = 0; i < n; i++) begin
      e.din = tb_mem[i][2:1];
      e.mis = (tb_mem[i][0] != ~&tb_mem[i][2:1]);
      sb.push_back(e);
      if (e.mis) errs++;
`ifdef TV_PLAYER_STOP_ON_ERROR_EN
      if (e.mis) begin
        last_idx = i;
        break;
      end
`endif
    end
    @(negedge clk);
    start     = 1'b1;
    num_tests = 6'(nt);
    @(negedge clk);
    start = 1'b0;
    if (n == 0) begin
      check("z_done", 32'(done),      32'd1);
      check("z_busy", 32'(busy),      32'd0);
      check("z_err",  32'(err_count), 32'd0);
      check("z_idx",  32'(vec_idx),   32'd0);
      return;
    end
    k = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check("apply_busy", 32'(busy),     32'd1);
      check("apply_mis",  32'(mismatch), 32'd0);
      @(negedge clk);
      if (disturb == int'(k)) begin
        ld_valid  = 1'b1;
        ld_addr   = 5'd0;
        ld_data   = ~tb_mem[0];
        start     = 1'b1;
        num_tests = 6'd1;
      end
      check("settle_din", 32'(dut_in),   32'(e.din));
      check("settle_mis", 32'(mismatch), 32'd0);
      @(negedge clk);
      ld_valid = 1'b0;
      start    = 1'b0;
      check("check_din", 32'(dut_in),   32'(e.din));
      check("check_mis", 32'(mismatch), 32'(e.mis));
      check("check_idx", 32'(vec_idx),  32'(k));
      last_din = e.din;
      k++;
      @(negedge clk);
    end
    check("end_done", 32'(done),      32'd1);
    check("end_busy", 32'(busy),      32'd0);
    check("end_err",  32'(err_count), 32'(errs));
    check("end_idx",  32'(vec_idx),   32'(last_idx));
    check("end_din",  32'(dut_in),    32'(last_din));
    check("end_mis",  32'(mismatch),  32'd0);
  endtask

  initial begin
    reset     = 1'b0;
    ld_valid  = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    start     = 1'b0;
    num_tests = '0;
    #1;
    check_idle_outputs("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Correct NAND table.
    load(0, 3'b001);
    load(1, 3'b011);
    load(2, 3'b101);
    load(3, 3'b110);
    run(4, -1);

    // Vector 2 wrong.
    load(2, 3'b100);
    run(4, -1);
    load(2, 3'b101);

    // Empty run, then oversized request on a fully loaded memory.
    run(0, -1);
    for (int unsigned i = 4; i < 32; i++) load(i, 3'($urandom_range(0, 7)));
    run(40, -1);

    // Abort during vector 2's settle cycle, then replay.
    @(negedge clk);
    start     = 1'b1;
    num_tests = 6'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle_outputs("abort");
    @(negedge clk);
    reset = 1'b1;
    run(4, -1);

    // Write and start during a run are ignored; the next run sees memory unchanged.
    run(4, 1);
    run(4, -1);

    // Vector 1 wrong.
    load(1, 3'b010);
    run(4, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 expected less");
    $fatal(1);
  end

endmodule
